// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } md_state_t;

  // Replicated across the quotient width on divide-by-zero (LO = all ones).
  localparam logic MD_DIV0_FILL = 1'b1;

endpackage

// File: rtl/muldiv_unit_core.sv
// Unsigned shift-add multiply / restoring divide datapath, one step per enable.
module md_iter_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_en,
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  logic             r_div;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shl;
  logic [WIDTH:0]   w_diff;

  // Multiply: {acc,lo} holds partial product over the shifting multiplier.
  // Divide: {acc,lo} holds remainder over the shifting dividend/quotient.
  always_comb begin
    w_sum  = {1'b0, r_acc} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_shl  = {r_acc, r_lo[WIDTH-1]};
    w_diff = w_shl - {1'b0, r_b};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= 1'b0;
      r_acc <= '0;
      r_lo  <= '0;
      r_b   <= '0;
    end else if (i_load) begin
      r_div <= i_div;
      r_acc <= '0;
      r_lo  <= i_a;
      r_b   <= i_b;
    end else if (i_en) begin
      if (r_div) begin
        r_acc <= w_diff[WIDTH] ? w_shl[WIDTH-1:0] : w_diff[WIDTH-1:0];
        r_lo  <= {r_lo[WIDTH-2:0], ~w_diff[WIDTH]};
      end else begin
        r_acc <= w_sum[WIDTH:1];
        r_lo  <= {w_sum[0], r_lo[WIDTH-1:1]};
      end
    end
  end

  assign o_hi = r_acc;
  assign o_lo = r_lo;

endmodule

// File: rtl/muldiv_unit.sv
// MIPS HI/LO multiply/divide unit: FSM, sign handling, HI/LO and stall request.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_E,
  input  logic [1:0]       op_E,
  input  logic [WIDTH-1:0] src_a_E,
  input  logic [WIDTH-1:0] src_b_E,
  input  logic             mf_D,
  input  logic             md_D,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall_md
);

  md_state_t          r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_b_zero;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_neg_a;
  logic               w_neg_b;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic               w_load;
  logic [WIDTH-1:0]   w_core_hi;
  logic [WIDTH-1:0]   w_core_lo;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;

  always_comb begin
    w_neg_a = ~op_E[0] & src_a_E[WIDTH-1];
    w_neg_b = ~op_E[0] & src_b_E[WIDTH-1];
    w_abs_a = w_neg_a ? -src_a_E : src_a_E;
    w_abs_b = w_neg_b ? -src_b_E : src_b_E;
    w_load  = start_E & (r_state == S_IDLE);
    w_prod  = r_neg_q ? -{w_core_hi, w_core_lo} : {w_core_hi, w_core_lo};
    w_quot  = r_neg_q ? -w_core_lo : w_core_lo;
    w_rem   = r_neg_r ? -w_core_hi : w_core_hi;
  end

  md_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .i_load(w_load),
    .i_en  (r_state == S_BUSY),
    .i_div (op_E[1]),
    .i_a   (w_abs_a),
    .i_b   (w_abs_b),
    .o_hi  (w_core_hi),
    .o_lo  (w_core_lo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_div    <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_b_zero <= 1'b0;
      r_a      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_E) begin
            r_div    <= op_E[1];
            r_neg_q  <= w_neg_a ^ w_neg_b;
            r_neg_r  <= w_neg_a;
            r_b_zero <= (src_b_E == '0);
            r_a      <= src_a_E;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(WIDTH - 1)) r_state <= S_DONE;
        end
        S_DONE: begin
          if (!r_div) begin
            {r_hi, r_lo} <= w_prod;
          end else if (r_b_zero) begin
            r_hi <= r_a;
            r_lo <= {WIDTH{MD_DIV0_FILL}};
          end else begin
            r_hi <= w_rem;
            r_lo <= w_quot;
          end
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign hi       = r_hi;
  assign lo       = r_lo;
  assign busy     = r_busy;
  assign stall_md = (r_busy | start_E) & (mf_D | md_D);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit with hand-computed results.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start_E;
  logic [1:0]  op_E;
  logic [31:0] src_a_E;
  logic [31:0] src_b_E;
  logic        mf_D;
  logic        md_D;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall_md;

  int unsigned passed = 0;
  int unsigned total  = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_E (start_E),
    .op_E    (op_E),
    .src_a_E (src_a_E),
    .src_b_E (src_b_E),
    .mf_D    (mf_D),
    .md_D    (md_D),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .stall_md(stall_md)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The hazard logic must never let a new op reach EX while one is in flight.
  always @(negedge clk) begin
    if (rst_n) begin
      assert (!(start_E && busy))
      else $error("FAIL start_while_busy observed start_E=1 busy=1 required not both");
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Issue one op from the current (post-edge) time and follow it to completion.
  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    int unsigned n;
    int unsigned hold_bad;
    int unsigned stall_bad;
    logic want_stall;
    old_hi    = hi;
    old_lo    = lo;
    hold_bad  = 0;
    stall_bad = 0;
    want_stall = mf_D | md_D;
    start_E = 1'b1;
    op_E    = op;
    src_a_E = a;
    src_b_E = b;
    #1;
    chk({tag, "_stall_start"}, {31'd0, stall_md}, {31'd0, want_stall});
    @(posedge clk);
    #1;
    start_E = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      if (hi !== old_hi || lo !== old_lo) hold_bad++;
      if (stall_md !== want_stall) stall_bad++;
      @(posedge clk);
      #1;
    end
    chk({tag, "_busy_cycles"}, n, 32'd33);
    chk({tag, "_hold"}, hold_bad, 32'd0);
    chk({tag, "_stall_busy"}, stall_bad, 32'd0);
    chk({tag, "_stall_after"}, {31'd0, stall_md}, 32'd0);
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    rst_n   = 1'b0;
    start_E = 1'b0;
    op_E    = MD_MULT;
    src_a_E = '0;
    src_b_E = '0;
    mf_D    = 1'b0;
    md_D    = 1'b0;
    #12;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    mf_D = 1'b1;
    #1;
    chk("rst_stall_idle", {31'd0, stall_md}, 32'd0);
    mf_D = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("mult_7_m3",   MD_MULT,  32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("multu_max",   MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("multu_2p16",  MD_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000);
    run_op("div_m7_2",    MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_7_m2",    MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
    run_op("divu_5_0",    MD_DIVU,  32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF);
    run_op("div_m7_0",    MD_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF);
    run_op("div_ovf",     MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

    // MFHI sits in ID behind the DIVU for the whole operation.
    mf_D = 1'b1;
    run_op("divu_100_7",  MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14);
    mf_D = 1'b0;

    // Second mult/div held in ID until the first completes, then issued.
    md_D = 1'b1;
    run_op("b2b_first",   MD_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001);
    md_D = 1'b0;
    run_op("b2b_second",  MD_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF);

    // Asynchronous reset in the middle of a multiply.
    start_E = 1'b1;
    op_E    = MD_MULT;
    src_a_E = 32'h12345678;
    src_b_E = 32'd3;
    @(posedge clk);
    #1;
    start_E = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_idle_busy", {31'd0, busy}, 32'd0);
    run_op("mult_3_4",    MD_MULT,  32'd3,        32'd4,        32'd0,        32'd12);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
